// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - one-hot compare result type and constants shared by cmp_stream (option CMP_SIGNED_EN)
package cmp_pkg;

    // One-hot {GT, EQ, LT}; all-zero means no result present
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_NONE = 3'b000;
    localparam cmp_res_t CMP_LT   = 3'b001;
    localparam cmp_res_t CMP_EQ   = 3'b010;
    localparam cmp_res_t CMP_GT   = 3'b100;

endpackage

// File: rtl/cmp_stream_if.sv
// rtl/cmp_stream_if.sv - operand/result handshake bundle of cmp_stream
interface cmp_stream_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic             out_lt;
    logic             out_eq;
    logic             out_gt;
    logic             out_chg;

    // Comparator side
    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_lt, out_eq, out_gt, out_chg
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_lt, out_eq, out_gt, out_chg
    );
endinterface

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational magnitude compare to one-hot result; signed mode only with CMP_SIGNED_EN
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output cmp_res_t         res
);

`ifdef CMP_SIGNED_EN
    // Two's-complement or unsigned ordering chosen per operand pair
    always_comb begin
        res = CMP_EQ;
        if (is_signed) begin
            if ($signed(a) < $signed(b)) begin
                res = CMP_LT;
            end else if ($signed(a) > $signed(b)) begin
                res = CMP_GT;
            end
        end else begin
            if (a < b) begin
                res = CMP_LT;
            end else if (a > b) begin
                res = CMP_GT;
            end
        end
    end
`else
    // Unsigned ordering only; is_signed has no effect in this build
    always_comb begin
        res = CMP_EQ;
        if (a < b) begin
            res = CMP_LT;
        end else if (a > b) begin
            res = CMP_GT;
        end
    end

    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

endmodule

// File: rtl/cmp_stream.sv
// rtl/cmp_stream.sv - two-stage streaming comparator with change flag and saturating counters (option CMP_SIGNED_EN)
module cmp_stream
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_stream_if.slave      io,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_signed;

    logic             s2_valid;
    cmp_res_t         s2_res;
    cmp_res_t         prev_res;
    cmp_res_t         core_res;

    logic             s1_adv;
    logic             s2_adv;
    logic             in_hs;
    logic             out_hs;

    logic [CNT_W-1:0] lt_q;
    logic [CNT_W-1:0] eq_q;
    logic [CNT_W-1:0] gt_q;

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_adv = !s2_valid || io.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign in_hs  = io.in_valid && s1_adv;
    assign out_hs = s2_valid && io.out_ready;

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid;
    assign io.out_lt    = s2_res[0];
    assign io.out_eq    = s2_res[1];
    assign io.out_gt    = s2_res[2];
    assign io.out_chg   = s2_valid && (s2_res != prev_res);

    assign cnt_lt = lt_q;
    assign cnt_eq = eq_q;
    assign cnt_gt = gt_q;

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (s1_a),
        .b         (s1_b),
        .is_signed (s1_signed),
        .res       (core_res)
    );

    // S1: capture the operand pair on input handshake, empty when nothing arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= io.in_valid;
            if (in_hs) begin
                s1_a      <= io.in_a;
                s1_b      <= io.in_b;
                s1_signed <= io.in_signed;
            end
        end
    end

    // S2: register the compare result; forced to CMP_NONE when empty so outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= CMP_NONE;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_res   <= s1_valid ? core_res : CMP_NONE;
        end
    end

    // Remember the last delivered result for the change flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_res <= CMP_NONE;
        end else if (out_hs) begin
            prev_res <= s2_res;
        end
    end

    // Per-result delivery counters; clear beats a coincident handshake, full counters hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= '0;
            eq_q <= '0;
            gt_q <= '0;
        end else if (cnt_clr) begin
            lt_q <= '0;
            eq_q <= '0;
            gt_q <= '0;
        end else if (out_hs) begin
            if (s2_res == CMP_LT && lt_q != CNT_MAX) begin
                lt_q <= lt_q + CNT_ONE;
            end
            if (s2_res == CMP_EQ && eq_q != CNT_MAX) begin
                eq_q <= eq_q + CNT_ONE;
            end
            if (s2_res == CMP_GT && gt_q != CNT_MAX) begin
                gt_q <= gt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cmp_stream.sv
// tb/tb_cmp_stream.sv - self-checking bench for cmp_stream with queue reference model (option CMP_SIGNED_EN)
module tb_cmp_stream;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_gt;

    cmp_stream_if #(.WIDTH(WIDTH)) bus ();

    cmp_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io      (bus),
        .cnt_clr (cnt_clr),
        .cnt_lt  (cnt_lt),
        .cnt_eq  (cnt_eq),
        .cnt_gt  (cnt_gt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [2:0] exp_q[$];
    logic [2:0] deliv[$];
    bit         chg_log[$];
    logic [2:0] prev_m = 3'b000;
    int         m_lt = 0;
    int         m_eq = 0;
    int         m_gt = 0;

    function automatic logic [2:0] ref_cmp(input int a, input int b, input bit sgn);
        int va;
        int vb;
        va = a;
        vb = b;
        if (sgn && SIGNED_EN) begin
            if (va >= (1 << (WIDTH - 1))) va = va - (1 << WIDTH);
            if (vb >= (1 << (WIDTH - 1))) vb = vb - (1 << WIDTH);
        end
        if (va < vb) return 3'b001;
        if (va == vb) return 3'b010;
        return 3'b100;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [2:0] deliv_at(input int i);
        if (i < deliv.size()) return deliv[i];
        return 3'b111;
    endfunction

    function automatic logic chg_at(input int i);
        if (i < chg_log.size()) return chg_log[i];
        return 1'bx;
    endfunction

    // Observe outputs mid-cycle, compare with the model, then apply this cycle's handshakes to the model
    task automatic sample();
        logic [2:0] got;
        logic [2:0] r;
        bit         in_hs;
        bit         out_hs;
        @(negedge clk);
        if (rst_n) begin
            got    = {bus.out_gt, bus.out_eq, bus.out_lt};
            in_hs  = bus.in_valid && bus.in_ready;
            out_hs = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    check("res", {29'd0, got}, {29'd0, exp_q[0]});
                    check("chg", {31'd0, bus.out_chg}, {31'd0, (exp_q[0] != prev_m)});
                end
            end else begin
                check("idle_res", {29'd0, got}, 32'd0);
                check("idle_chg", {31'd0, bus.out_chg}, 32'd0);
            end
            check("cnt_lt", 32'(cnt_lt), 32'(m_lt));
            check("cnt_eq", 32'(cnt_eq), 32'(m_eq));
            check("cnt_gt", 32'(cnt_gt), 32'(m_gt));
            if (out_hs && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                deliv.push_back(r);
                chg_log.push_back(r != prev_m);
                prev_m = r;
                if (!cnt_clr) begin
                    if (r == 3'b001) m_lt = sat_inc(m_lt);
                    if (r == 3'b010) m_eq = sat_inc(m_eq);
                    if (r == 3'b100) m_gt = sat_inc(m_gt);
                end
            end
            if (cnt_clr) begin
                m_lt = 0;
                m_eq = 0;
                m_gt = 0;
            end
            if (in_hs) exp_q.push_back(ref_cmp(int'(bus.in_a), int'(bus.in_b), bus.in_signed));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic drive(input bit v, input int a, input int b, input bit s);
        bus.in_valid  = v;
        bus.in_a      = WIDTH'(a);
        bus.in_b      = WIDTH'(b);
        bus.in_signed = s;
    endtask

    task automatic send(input int a, input int b, input bit s);
        drive(1'b1, a, b, s);
        sample();
        advance();
    endtask

    task automatic clear_logs();
        deliv.delete();
        chg_log.delete();
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        sample();
        advance();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a4[4];
        int         b4[4];
        logic [2:0] e4[4];
        logic [2:0] snap;
        int         idx;
        int         budget;

        a4 = '{1, 2, 3, 0};
        b4 = '{2, 2, 1, 4};
        e4 = '{3'b001, 3'b010, 3'b100, 3'b001};

        drive(1'b0, 0, 0, 1'b0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_res", {29'd0, bus.out_gt, bus.out_eq, bus.out_lt}, 32'd0);
        check("rst_chg", {31'd0, bus.out_chg}, 32'd0);
        check("rst_cnt", {cnt_lt, cnt_eq, cnt_gt}, 32'd0);

        // Back-to-back LT, EQ, GT with latency checks
        clear_logs();
        drive(1'b1, 3, 5, 1'b0);
        sample();
        check("t1_accept", {31'd0, bus.in_ready}, 32'd1);
        advance();
        drive(1'b1, 5, 5, 1'b0);
        sample();
        check("t1_lat_empty", {31'd0, bus.out_valid}, 32'd0);
        advance();
        drive(1'b1, 9, 2, 1'b0);
        sample();
        check("t1_lat_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_lat_lt", {31'd0, bus.out_lt}, 32'd1);
        advance();
        drive(1'b0, 0, 0, 1'b0);
        run(4);
        check("t1_count", deliv.size(), 32'd3);
        check("t1_r0", {29'd0, deliv_at(0)}, 32'd1);
        check("t1_r1", {29'd0, deliv_at(1)}, 32'd2);
        check("t1_r2", {29'd0, deliv_at(2)}, 32'd4);
        check("t1_chg", {29'd0, chg_at(0), chg_at(1), chg_at(2)}, 32'd7);
        check("t1_cnts", {26'd0, cnt_gt, cnt_eq, cnt_lt}, {26'd0, 2'd1, 2'd1, 2'd1});

        // Signed vs unsigned interpretation of 4'hF against 4'h1
        clear_logs();
        send(15, 1, 1'b1);
        send(15, 1, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        run(4);
        check("sgn_count", deliv.size(), 32'd2);
        check("sgn_signed", {29'd0, deliv_at(0)}, SIGNED_EN ? 32'd1 : 32'd4);
        check("sgn_unsigned", {29'd0, deliv_at(1)}, 32'd4);

        // Repeated equal pairs: change flag only on the first
        pulse_clr();
        clear_logs();
        repeat (3) send(7, 7, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        run(4);
        check("rep_chg", {29'd0, chg_at(0), chg_at(1), chg_at(2)}, 32'd4);
        check("rep_cnt_eq", 32'(cnt_eq), 32'd3);

        // Back-pressure: two pairs absorbed, outputs frozen, then all four delivered in order
        clear_logs();
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) drive(1'b1, a4[idx], b4[idx], 1'b0);
            else drive(1'b0, 0, 0, 1'b0);
            sample();
            if (c >= 2) check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            if (c == 2) snap = {bus.out_gt, bus.out_eq, bus.out_lt};
            if (c > 2) begin
                check("stall_hold", {29'd0, bus.out_gt, bus.out_eq, bus.out_lt}, {29'd0, snap});
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            advance();
        end
        check("stall_acc", idx, 32'd2);
        bus.out_ready = 1'b1;
        budget = 0;
        while (deliv.size() < 4 && budget < 20) begin
            if (idx < 4) drive(1'b1, a4[idx], b4[idx], 1'b0);
            else drive(1'b0, 0, 0, 1'b0);
            sample();
            if (bus.in_valid && bus.in_ready) idx++;
            advance();
            budget++;
        end
        drive(1'b0, 0, 0, 1'b0);
        check("stall_count", deliv.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("stall_order", {29'd0, deliv_at(i)}, {29'd0, e4[i]});

        // Saturation at 2^CNT_W-1 and clear winning over a handshake
        pulse_clr();
        repeat (5) send(0, 1, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        run(4);
        check("sat_cnt_lt", 32'(cnt_lt), 32'd3);
        send(1, 2, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        budget = 0;
        while (!bus.out_valid && budget < 10) begin
            sample();
            advance();
            budget++;
        end
        check("clr_reach", {31'd0, bus.out_valid}, 32'd1);
        cnt_clr = 1'b1;
        sample();
        check("clr_hs", {31'd0, bus.out_valid && bus.out_ready}, 32'd1);
        advance();
        cnt_clr = 1'b0;
        check("clr_wins", 32'(cnt_lt), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            sample();
            advance();
        end
        drive(1'b0, 0, 0, 1'b0);
        bus.out_ready = 1'b1;
        cnt_clr = 1'b0;
        run(5);
        check("rand_drained", exp_q.size(), 32'd0);

        // Asynchronous reset with two pairs in flight
        bus.out_ready = 1'b0;
        send(2, 3, 1'b0);
        send(4, 1, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mid_res", {29'd0, bus.out_gt, bus.out_eq, bus.out_lt}, 32'd0);
        check("rst_mid_cnt", {26'd0, cnt_gt, cnt_eq, cnt_lt}, 32'd0);
        exp_q.delete();
        prev_m = 3'b000;
        m_lt = 0;
        m_eq = 0;
        m_gt = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear_logs();
        run(5);
        check("rst_no_stale", deliv.size(), 32'd0);
        send(5, 5, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        run(3);
        check("rst_first_chg", {31'd0, chg_at(0)}, 32'd1);
        check("rst_cnt_eq", 32'(cnt_eq), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
